spi_mstr_arb: RTL

Sequencer/arbiter that shares one 16-bit SPI master (`SPI_mstr16`) between up to four requesters, for example the inertial sensor interface and the A2D interface. It accepts level requests with 16-bit commands, issues one `wrt` pulse per granted transaction, and waits for the master's `done`. It then returns the 16-bit read data to the granted requester and enforces a minimum idle gap before the next transaction. It sits directly between the requester blocks and the master's `wrt`/`cmd`/`done`/`rd_data` pins.

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_mstr_arb_if.sv | 37 +++
 rtl/spi_arb_pick.sv | 58 +++++
 rtl/spi_mstr_arb.sv | 136 +++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// ============================================================================
// spi_arb_pkg : shared types and constants for the SPI master arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_arb_pkg;

  localparam int SPI_W   = 16;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_mstr_arb_if.sv
// ============================================================================
// spi_mstr_arb_if : requester-side and SPI-master-side pins of the arbiter.
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface spi_mstr_arb_if #(
  parameter int NREQ = 2
);
  import spi_arb_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*SPI_W-1:0] req_cmd;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_vld;
  logic [SPI_W-1:0]      rsp_data;
  logic                  busy;
  logic                  mstr_wrt;
  logic [SPI_W-1:0]      mstr_cmd;
  logic                  mstr_done;
  logic [SPI_W-1:0]      mstr_rd_data;

  // The arbiter itself.
  modport slave (
    input  req, req_cmd, mstr_done, mstr_rd_data,
    output gnt, rsp_vld, rsp_data, busy, mstr_wrt, mstr_cmd
  );

  // Requesters plus SPI master, i.e. everything around the arbiter.
  modport master (
    output req, req_cmd, mstr_done, mstr_rd_data,
    input  gnt, rsp_vld, rsp_data, busy, mstr_wrt, mstr_cmd
  );

endinterface

`default_nettype wire

// File: rtl/spi_arb_pick.sv
// ============================================================================
// spi_arb_pick : combinational winner selection (one-hot grant + index).
// Build macro  : SPI_MSTR_ARB_RR_EN selects round-robin, else fixed priority.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_arb_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
`ifdef SPI_MSTR_ARB_RR_EN
  input  logic [$clog2(NREQ)-1:0] ptr,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic found;

`ifdef SPI_MSTR_ARB_RR_EN
  logic [IDX_W-1:0] pos;

  // Search begins at ptr, which already points one past the last winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end
`else
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/spi_mstr_arb.sv
// ============================================================================
// spi_mstr_arb : shares one 16-bit SPI master between NREQ requesters.
// Build macro  : SPI_MSTR_ARB_RR_EN enables round-robin arbitration.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_mstr_arb
  import spi_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mstr_arb_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // GAP lasts GAP_CYCLES cycles, so the counter is loaded one short.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [SPI_W-1:0]   rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               wrt_q, wrt_d;
  logic [SPI_W-1:0]   cmd_q, cmd_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   win_q, win_d;
`ifdef SPI_MSTR_ARB_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  logic [NREQ-1:0]    w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;

  spi_arb_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
`ifdef SPI_MSTR_ARB_RR_EN
    .ptr (ptr_q),
`endif
    .gnt (w_pick_gnt),
    .idx (w_pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    gap_d      = gap_q;
    win_d      = win_q;
`ifdef SPI_MSTR_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = w_pick_gnt;
          win_d   = w_pick_idx;
          wrt_d   = 1'b1;
          state_d = ISSUE;
          for (int k = 0; k < NREQ; k++) begin
            if (w_pick_gnt[k]) cmd_d = bus.req_cmd[k*SPI_W +: SPI_W];
          end
`ifdef SPI_MSTR_ARB_RR_EN
          ptr_d = (int'(w_pick_idx) == NREQ - 1) ? '0 : w_pick_idx + 1'b1;
`endif
        end
      end
      // done is ignored here: the master only clears it on this wrt edge.
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (bus.mstr_done) begin
          rsp_data_d        = bus.mstr_rd_data;
          rsp_vld_d[win_q]  = 1'b1;
          gnt_d             = '0;
          gap_d             = GAP_LOAD;
          state_d           = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      busy_q     <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= '0;
      gap_q      <= '0;
      win_q      <= '0;
`ifdef SPI_MSTR_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      busy_q     <= busy_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      gap_q      <= gap_d;
      win_q      <= win_d;
`ifdef SPI_MSTR_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.busy     = busy_q;
  assign bus.mstr_wrt = wrt_q;
  assign bus.mstr_cmd = cmd_q;

endmodule

`default_nettype wire
